// File: rtl/fruit_dropper_if.sv
// Fruit lane bus: game controls in, fruit position and status out.
// Latency: n/a (wires only).
// Backpressure: none; tick/collision are strobes, outputs are levels/pulses.
//
// Signals:
//   enable, tick, collision        -> driven by game logic / collisionDetect
//   X_fruit, Y_fruit, active       -> fruit position and visibility
//   caught, missed                 -> one-cycle event pulses
//   miss_count, game_over          -> score/end status
interface fruit_dropper_if;
    logic       enable;
    logic       tick;
    logic       collision;
    logic [7:0] X_fruit;
    logic [6:0] Y_fruit;
    logic       active;
    logic       caught;
    logic       missed;
    logic [3:0] miss_count;
    logic       game_over;

    // master: the fruit dropper itself
    modport master (
        input  enable, tick, collision,
        output X_fruit, Y_fruit, active, caught, missed, miss_count, game_over
    );

    // slave: whoever drives the game controls and consumes the fruit stream
    modport slave (
        output enable, tick, collision,
        input  X_fruit, Y_fruit, active, caught, missed, miss_count, game_over
    );
endinterface

// File: rtl/fruit_dropper.sv
// Spawns a fruit at a pseudo-random X, drops it on frame ticks, reports catch/miss.
// Latency: all outputs registered; collision -> caught/active fall in 1 cycle.
// Backpressure: none; enable=0 freezes all state and drops ticks/collisions.
//
// Ports:
//   Clock, Resetn  : clock and asynchronous active-low reset
//   bus (master)   : enable/tick/collision in; X_fruit, Y_fruit, active,
//                    caught, missed, miss_count, game_over out
module fruit_dropper #(
    parameter int         SCREEN_W      = 160,
    parameter int         SCREEN_H      = 120,
    parameter int         FRUIT_SIZE    = 8,
    parameter int         FALL_DIV      = 2,
    parameter int         RESPAWN_TICKS = 30,
    parameter int         MAX_MISSES    = 3,
    parameter logic [7:0] SEED          = 8'hA5
) (
    input  logic            Clock,
    input  logic            Resetn,
    fruit_dropper_if.master bus
);

    localparam logic [7:0]  X_SPAN    = 8'(SCREEN_W - FRUIT_SIZE);
    localparam logic [6:0]  BOTTOM    = 7'(SCREEN_H - FRUIT_SIZE);
    localparam logic [15:0] DIV_LAST  = 16'(FALL_DIV - 1);
    localparam logic [15:0] WAIT_LAST = 16'(RESPAWN_TICKS - 1);
    localparam logic [3:0]  MISS_MAX  = 4'(MAX_MISSES);

    typedef enum logic [2:0] {IDLE, SPAWN, FALL, WAIT, OVER} state_t;

    state_t      state_q, state_nxt;
    logic [7:0]  lfsr_q, lfsr_nxt;
    logic [7:0]  x_q, x_nxt;
    logic [6:0]  y_q, y_nxt;
    logic [15:0] div_q, div_nxt;
    logic [15:0] wait_q, wait_nxt;
    logic        active_q, active_nxt;
    logic        caught_q, caught_nxt;
    logic        missed_q, missed_nxt;
    logic [3:0]  miss_q, miss_nxt;
    logic        over_q, over_nxt;

    logic [7:0]  lfsr_step;
    logic [7:0]  spawn_x;
    logic [3:0]  miss_inc;

    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    // An 8-bit value is below 2*X_SPAN, so one conditional subtract is a full modulo.
    assign spawn_x   = (lfsr_q >= X_SPAN) ? (lfsr_q - X_SPAN) : lfsr_q;
    assign miss_inc  = (miss_q == 4'hF) ? miss_q : (miss_q + 4'd1);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            x_q      <= '0;
            y_q      <= '0;
            div_q    <= '0;
            wait_q   <= '0;
            active_q <= 1'b0;
            caught_q <= 1'b0;
            missed_q <= 1'b0;
            miss_q   <= '0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            lfsr_q   <= lfsr_nxt;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            div_q    <= div_nxt;
            wait_q   <= wait_nxt;
            active_q <= active_nxt;
            caught_q <= caught_nxt;
            missed_q <= missed_nxt;
            miss_q   <= miss_nxt;
            over_q   <= over_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        lfsr_nxt   = lfsr_q;
        x_nxt      = x_q;
        y_nxt      = y_q;
        div_nxt    = div_q;
        wait_nxt   = wait_q;
        active_nxt = active_q;
        caught_nxt = 1'b0;     // pulses self-clear, even while frozen
        missed_nxt = 1'b0;
        miss_nxt   = miss_q;
        over_nxt   = over_q;

        if (bus.enable) begin
            case (state_q)
                IDLE: begin
                    active_nxt = 1'b0;
                    state_nxt  = SPAWN;
                end
                SPAWN: begin
                    x_nxt      = spawn_x;
                    y_nxt      = '0;
                    div_nxt    = '0;
                    active_nxt = 1'b1;
                    lfsr_nxt   = lfsr_step;
                    state_nxt  = FALL;
                end
                FALL: begin
                    // Catch takes priority over a step due in the same cycle.
                    if (bus.collision) begin
                        caught_nxt = 1'b1;
                        active_nxt = 1'b0;
                        wait_nxt   = '0;
                        state_nxt  = WAIT;
                    end else if (bus.tick) begin
                        if (div_q >= DIV_LAST) begin
                            div_nxt = '0;
                            if (y_q < BOTTOM) begin
                                y_nxt = y_q + 7'd1;
                            end else begin
                                missed_nxt = 1'b1;
                                miss_nxt   = miss_inc;
                                active_nxt = 1'b0;
                                wait_nxt   = '0;
                                if (miss_inc >= MISS_MAX) begin
                                    over_nxt  = 1'b1;
                                    state_nxt = OVER;
                                end else begin
                                    state_nxt = WAIT;
                                end
                            end
                        end else begin
                            div_nxt = div_q + 16'd1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.tick) begin
                        if (wait_q >= WAIT_LAST) begin
                            wait_nxt  = '0;
                            state_nxt = SPAWN;
                        end else begin
                            wait_nxt = wait_q + 16'd1;
                        end
                    end
                end
                OVER: begin
                    active_nxt = 1'b0;
                    over_nxt   = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.X_fruit    = x_q;
    assign bus.Y_fruit    = y_q;
    assign bus.active     = active_q;
    assign bus.caught     = caught_q;
    assign bus.missed     = missed_q;
    assign bus.miss_count = miss_q;
    assign bus.game_over  = over_q;

endmodule
